// File: rtl/mem2_load_stage_pkg.sv
// Shared definitions for the second-half memory stage: instruction field
// positions, load opcodes, exception width and the response-tracking FSM states.
package mem2_load_stage_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int EXC_WIDTH = 5;

  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_LWX  = 6'b111100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] opcode);
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWX: is_load = 1'b1;
      default:                                     is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem2_load_stage_load_ext.sv
// Load data alignment: picks the addressed byte/halfword lane from the read
// word and sign- or zero-extends it according to the load opcode.
module load_ext
  import mem2_load_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Non-load opcodes fall through to the raw word; the stage never captures them.
  always_comb begin
    data = rdata;
    case (opcode)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem2_load_stage.sv
// Second half of the memory stage: waits for the data SRAM response, stalls the
// pipeline while it is outstanding, drains responses of flushed accesses.
module mem2_load_stage
  import mem2_load_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          IR_MMID,
  input  logic [31:0]          PC8_MMID,
  input  logic [31:0]          ALUOUT_MMID,
  input  logic [31:0]          RT_MMID,
  input  logic [31:0]          XALUOUT_MMID,
  input  logic [EXC_WIDTH-1:0] EXC_MMID,
  input  logic [3:0]           byte_en,
  input  logic                 valid_mmid,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 data_sram_data_ok,
  input  logic                 flush,
  output logic [31:0]          IR_W,
  output logic [31:0]          PC8_W,
  output logic [31:0]          ALUOUT_W,
  output logic [31:0]          XALUOUT_W,
  output logic [31:0]          DMOUT_W,
  output logic [EXC_WIDTH-1:0] EXC_W,
  output logic                 valid_w,
  output logic                 stall_m,
  output logic [1:0]           state_dbg
);

  state_t      state;
  logic        access;
  logic        complete;
  logic [31:0] ext_data;
  logic        unused_rt;

  // Store data was consumed by the first half; nothing here needs it.
  assign unused_rt = ^RT_MMID;

  assign access = valid_mmid & (byte_en != 4'd0) & (EXC_MMID == '0) & ~flush;

  assign stall_m = ((state == ST_IDLE) & access & ~data_sram_data_ok)
                 | ((state == ST_WAIT) & ~data_sram_data_ok & ~flush)
                 | (state == ST_DRAIN);

  // A response completes only for a live access; drained or stray pulses are dropped.
  assign complete = data_sram_data_ok &
                    (((state == ST_IDLE) & access) | ((state == ST_WAIT) & ~flush));

  assign state_dbg = state;

  load_ext u_load_ext (
    .rdata  (data_sram_rdata),
    .addr   (ALUOUT_MMID[1:0]),
    .opcode (IR_MMID[OPC_MSB:OPC_LSB]),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      IR_W      <= '0;
      PC8_W     <= '0;
      ALUOUT_W  <= '0;
      XALUOUT_W <= '0;
      DMOUT_W   <= '0;
      EXC_W     <= '0;
      valid_w   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (access && !data_sram_data_ok) state <= ST_WAIT;
        ST_WAIT: begin
          if (data_sram_data_ok) state <= ST_IDLE;
          else if (flush)        state <= ST_DRAIN;
        end
        ST_DRAIN: if (data_sram_data_ok) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (stall_m || flush) begin
        IR_W    <= '0;
        EXC_W   <= '0;
        valid_w <= 1'b0;
      end else begin
        IR_W      <= IR_MMID;
        PC8_W     <= PC8_MMID;
        ALUOUT_W  <= ALUOUT_MMID;
        XALUOUT_W <= XALUOUT_MMID;
        EXC_W     <= EXC_MMID;
        valid_w   <= valid_mmid;
      end

      if (complete && is_load(IR_MMID[OPC_MSB:OPC_LSB])) DMOUT_W <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem2_load_stage.sv
// Directed bench for mem2_load_stage: zero-wait and multi-cycle loads, exception
// pass-through, flush drain and asynchronous reset during an outstanding access.
module tb_mem2_load_stage;

  logic        clk;
  logic        reset;
  logic [31:0] IR_MMID, PC8_MMID, ALUOUT_MMID, RT_MMID, XALUOUT_MMID;
  logic [4:0]  EXC_MMID;
  logic [3:0]  byte_en;
  logic        valid_mmid;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        flush;
  logic [31:0] IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DMOUT_W;
  logic [4:0]  EXC_W;
  logic        valid_w;
  logic        stall_m;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  mem2_load_stage dut (
    .clk               (clk),
    .reset             (reset),
    .IR_MMID           (IR_MMID),
    .PC8_MMID          (PC8_MMID),
    .ALUOUT_MMID       (ALUOUT_MMID),
    .RT_MMID           (RT_MMID),
    .XALUOUT_MMID      (XALUOUT_MMID),
    .EXC_MMID          (EXC_MMID),
    .byte_en           (byte_en),
    .valid_mmid        (valid_mmid),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_data_ok (data_sram_data_ok),
    .flush             (flush),
    .IR_W              (IR_W),
    .PC8_W             (PC8_W),
    .ALUOUT_W          (ALUOUT_W),
    .XALUOUT_W         (XALUOUT_W),
    .DMOUT_W           (DMOUT_W),
    .EXC_W             (EXC_W),
    .valid_w           (valid_w),
    .stall_m           (stall_m),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  // driver: sidebands are derived from ALUOUT so W-register copies are checkable
  task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [4:0] exc,
                       input logic [3:0] be, input logic v, input logic ok,
                       input logic [31:0] rd, input logic fl);
    IR_MMID           = ir;
    ALUOUT_MMID       = alu;
    PC8_MMID          = alu ^ 32'h0040_0008;
    XALUOUT_MMID      = ~alu;
    RT_MMID           = rd;
    EXC_MMID          = exc;
    byte_en           = be;
    valid_mmid        = v;
    data_sram_data_ok = ok;
    data_sram_rdata   = rd;
    flush             = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [3:0]  be;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{6'b100000, 32'h0000_0003, 4'b1000, 32'h8011_2233, 32'hFFFF_FF80};
    vecs[1] = '{6'b100001, 32'h0000_0010, 4'b0011, 32'h0000_8765, 32'hFFFF_8765};
    vecs[2] = '{6'b100100, 32'h0000_0021, 4'b0010, 32'h0000_9A00, 32'h0000_009A};
    vecs[3] = '{6'b100011, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{6'b111100, 32'h0000_0204, 4'b1111, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[5] = '{6'b100000, 32'h0000_0302, 4'b0100, 32'h0045_0000, 32'h0000_0045};

    reset = 1'b1;
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) step();
    check("rst_ir",    IR_W, 32'h0);
    check("rst_pc8",   PC8_W, 32'h0);
    check("rst_dm",    DMOUT_W, 32'h0);
    check("rst_exc",   {27'd0, EXC_W}, 32'h0);
    check("rst_valid", {31'd0, valid_w}, 32'h0);
    check("rst_stall", {31'd0, stall_m}, 32'h0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    step();

    // zero-wait loads of every flavour
    for (int i = 0; i < 6; i++) begin
      drive({vecs[i].op, 26'h0012345}, vecs[i].alu, 5'd0, vecs[i].be, 1'b1, 1'b1,
            vecs[i].rd, 1'b0);
      exp_q.push_back(vecs[i].exp);
      check($sformatf("zw%0d_stall", i), {31'd0, stall_m}, 32'h0);
      step();
      check($sformatf("zw%0d_dm", i), DMOUT_W, exp_q.pop_front());
      check($sformatf("zw%0d_valid", i), {31'd0, valid_w}, 32'h1);
      check($sformatf("zw%0d_ir", i), IR_W, {vecs[i].op, 26'h0012345});
      check($sformatf("zw%0d_pc8", i), PC8_W, vecs[i].alu ^ 32'h0040_0008);
    end
    check("zw_xalu", XALUOUT_W, 32'hFFFF_FCFD);

    // lhu upper half, response after three waiting cycles
    for (int c = 0; c < 3; c++) begin
      drive({6'b100101, 26'h0000ABC}, 32'h0000_1002, 5'd0, 4'b1100, 1'b1, 1'b0,
            32'h0, 1'b0);
      check($sformatf("lhu_stall%0d", c), {31'd0, stall_m}, 32'h1);
      step();
      check($sformatf("lhu_bub_ir%0d", c), IR_W, 32'h0);
      check($sformatf("lhu_bub_v%0d", c), {31'd0, valid_w}, 32'h0);
      check($sformatf("lhu_dm_hold%0d", c), DMOUT_W, 32'h0000_0045);
      check($sformatf("lhu_state%0d", c), {30'd0, state_dbg}, 32'd1);
    end
    check("lhu_pc8_hold", PC8_W, 32'h0040_030A);
    drive({6'b100101, 26'h0000ABC}, 32'h0000_1002, 5'd0, 4'b1100, 1'b1, 1'b1,
          32'h8001_1234, 1'b0);
    check("lhu_done_stall", {31'd0, stall_m}, 32'h0);
    step();
    check("lhu_dm",    DMOUT_W, 32'h0000_8001);
    check("lhu_valid", {31'd0, valid_w}, 32'h1);
    check("lhu_state", {30'd0, state_dbg}, 32'd0);

    // store carrying an exception: no access, exception passes through
    drive({6'b101011, 26'h0}, 32'h0000_0040, 5'd5, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("exc_stall", {31'd0, stall_m}, 32'h0);
    step();
    check("exc_code",  {27'd0, EXC_W}, 32'd5);
    check("exc_valid", {31'd0, valid_w}, 32'h1);
    check("exc_dm",    DMOUT_W, 32'h0000_8001);

    // stray response with nothing in the slot
    drive({6'b100011, 26'h0}, 32'h0, 5'd0, 4'b1111, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("stray_stall", {31'd0, stall_m}, 32'h0);
    step();
    check("stray_dm",    DMOUT_W, 32'h0000_8001);
    check("stray_valid", {31'd0, valid_w}, 32'h0);
    check("stray_state", {30'd0, state_dbg}, 32'd0);

    // lw flushed while waiting; late response is drained, never written
    drive({6'b100011, 26'h0}, 32'h0000_0080, 5'd0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    drive({6'b100011, 26'h0}, 32'h0000_0080, 5'd0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    check("fl_wait_stall", {31'd0, stall_m}, 32'h1);
    step();
    drive({6'b100011, 26'h0}, 32'h0000_0080, 5'd0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("fl_bub_valid", {31'd0, valid_w}, 32'h0);
    check("fl_state_c3",  {30'd0, state_dbg}, 32'd2);
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fl_drain_stall3", {31'd0, stall_m}, 32'h1);
    step();
    check("fl_state_c4", {30'd0, state_dbg}, 32'd2);
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    check("fl_drain_stall4", {31'd0, stall_m}, 32'h1);
    step();
    check("fl_dm",       DMOUT_W, 32'h0000_8001);
    check("fl_state_c5", {30'd0, state_dbg}, 32'd0);
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fl_idle_stall", {31'd0, stall_m}, 32'h0);

    // asynchronous reset while an access is outstanding
    drive({6'b100011, 26'h0}, 32'h0000_00C0, 5'd0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    check("rw_state_wait", {30'd0, state_dbg}, 32'd1);
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    check("rw_state", {30'd0, state_dbg}, 32'd0);
    check("rw_dm",    DMOUT_W, 32'h0);
    check("rw_pc8",   PC8_W, 32'h0);
    check("rw_alu",   ALUOUT_W, 32'h0);
    check("rw_stall", {31'd0, stall_m}, 32'h0);
    step();
    reset = 1'b0;
    step();
    drive(32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    step();
    check("rw_stray_dm",    DMOUT_W, 32'h0);
    check("rw_stray_state", {30'd0, state_dbg}, 32'd0);
    check("rw_stray_valid", {31'd0, valid_w}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem2_load_stage.md
MEM2_LOAD_STAGE -- requirements
Module: mem2_load_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: IR_MMID, PC8_MMID, ALUOUT_MMID, RT_MMID, XALUOUT_MMID  in  32 each  first-half memory stage outputs.
REQ-003 SHALL have ports: EXC_MMID  in  5  exception code, 0 = none; byte_en  in  4  access lanes, 0 = no access; valid_mmid  in  1  slot holds a real instruction.
REQ-004 SHALL have ports: data_sram_rdata  in  32  read data; data_sram_data_ok  in  1  single-cycle response pulse, one per access (load or store).
REQ-005 SHALL have ports: flush  in  1  exception/eret flush of this slot.
REQ-006 SHALL have ports: IR_W, PC8_W, ALUOUT_W, XALUOUT_W, DMOUT_W  out  32 each; EXC_W  out  5; valid_w  out  1.
REQ-007 SHALL have port: stall_m  out  1  holds the first-half stage and all upstream stages.

Function
REQ-008 SHALL define access = valid_mmid & (byte_en != 0) & (EXC_MMID == 0) & ~flush.
REQ-009 SHALL treat opcode IR[31:26] 100000/100100 as lb/lbu, 100001/100101 as lh/lhu, 100011 and 111100 as word loads; all other opcodes as non-loads.
REQ-010 SHALL implement FSM IDLE, WAIT, DRAIN.
REQ-011 In IDLE: access & ~data_ok -> WAIT; otherwise stay in IDLE.
REQ-012 In WAIT: data_ok & ~flush -> IDLE; flush & ~data_ok -> DRAIN; flush & data_ok -> IDLE, with the result discarded.
REQ-013 In DRAIN: data_ok -> IDLE; otherwise stay in DRAIN; data_ok SHALL only be absorbed, never written back.
REQ-014 stall_m SHALL equal (IDLE & access & ~data_ok) | (WAIT & ~data_ok & ~flush) | DRAIN, combinationally.
REQ-015 A zero-wait response (data_ok in the IDLE access cycle) SHALL complete with no stall.
REQ-016 When stall_m = 0, the W register SHALL load the MMID fields; EXC_W = EXC_MMID; valid_w = valid_mmid & ~flush.
REQ-017 When stall_m = 1 or flush = 1, the W register SHALL load a bubble: IR_W = 0, valid_w = 0, EXC_W = 0, other outputs unchanged.
REQ-018 DMOUT_W SHALL be captured from data_sram_rdata only on the completing data_ok cycle of a load; otherwise it holds its value.
REQ-019 Byte loads SHALL select lane ALUOUT[1:0] (0 = bits 7:0 ... 3 = bits 31:24); lb sign-extends, lbu zero-extends.
REQ-020 Halfword loads SHALL select ALUOUT[1] (0 = bits 15:0, 1 = bits 31:16); lh sign-extends, lhu zero-extends.
REQ-021 Word loads SHALL pass rdata unchanged.
REQ-022 Any data_ok in IDLE without access SHALL be ignored.
REQ-023 An instruction carrying EXC_MMID != 0 SHALL never stall and SHALL propagate its EXC to EXC_W.

Reset
REQ-024 On reset assertion: FSM -> IDLE; all W outputs = 0; valid_w = 0; stall_m reflects IDLE immediately.
REQ-025 Reset while in WAIT or DRAIN SHALL abandon the outstanding response; the SRAM side is reset concurrently.

Structure
REQ-026 Opcode constants, FSM state encoding, and the 5-bit EXC width SHALL reside in the shared header alongside the existing field macros.
REQ-027 Load extension SHALL be a separate combinational sub-module, load_ext (inputs rdata, addr[1:0], opcode; output 32-bit data).

Verification
REQ-028 Load lb, ALUOUT = 0x...03, rdata = 0x80112233, zero-wait -> DMOUT_W = 0xFFFFFF80, valid_w = 1, no stall.
REQ-029 Load lhu, ALUOUT[1] = 1, rdata = 0x8001_1234, data_ok after 3 cycles -> stall_m = 1 for 3 cycles, 3 bubbles issued, then DMOUT_W = 0x00008001.
REQ-030 sw with EXC_MMID = 5, byte_en = 0 -> no stall, EXC_W = 5, valid_w = 1.
REQ-031 lw in WAIT, flush on cycle 2, data_ok on cycle 4 -> DRAIN for cycles 2-4, stall_m = 1, no W write of the data, IDLE on cycle 5.
REQ-032 Reset asserted mid-WAIT -> outputs immediately 0, FSM IDLE; a later stray data_ok is ignored.
